// File: rtl/cp0_ctrl_pkg.sv
// rtl/cp0_ctrl_pkg.sv - shared CP0 exception codes, FSM and event-kind encodings
package cp0_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_MOD  = 5'h01;
  localparam logic [4:0] EXC_TLBL = 5'h02;
  localparam logic [4:0] EXC_TLBS = 5'h03;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_IBE  = 5'h06;
  localparam logic [4:0] EXC_DBE  = 5'h07;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_CPU  = 5'h0b;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC00380;

  typedef enum logic [1:0] {ST_IDLE, ST_COMMIT, ST_FLUSH, ST_REDIRECT} state_e;
  typedef enum logic [1:0] {EV_NONE, EV_INT, EV_EXC, EV_ERET} kind_e;

  function automatic logic is_addr_err(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_int_detect.sv
// rtl/cp0_int_detect.sv - combinational pending-interrupt request from Status/Cause/hw_int
module cp0_int_detect (
  input  logic       ie,
  input  logic       exl,
  input  logic [7:0] im,
  input  logic [1:0] sw_ip,
  input  logic [5:0] hw_int,
  output logic       int_req
);

  assign int_req = ie & ~exl & (|({hw_int, sw_ip} & im));

endmodule

// File: rtl/cp0_exc_commit_ctrl.sv
// rtl/cp0_exc_commit_ctrl.sv - exception/ERET commit sequencer: CP0 strobes, flush, redirect
module cp0_exc_commit_ctrl
  import cp0_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic        wb_is_exc,
  input  logic [4:0]  wb_excCode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_badvaddr,
  input  logic        wb_is_in_ds,
  input  logic        wb_is_eret,
  input  logic [5:0]  hw_int,
  input  logic [31:0] cp0_Status,
  input  logic [31:0] cp0_Cause,
  input  logic [31:0] cp0_EPC,
  input  logic        redirect_ack,
  output logic        epc_we,
  output logic [31:0] epc_wdata,
  output logic        cause_we,
  output logic [4:0]  cause_excCode,
  output logic        cause_bd,
  output logic        badvaddr_we,
  output logic [31:0] badvaddr_wdata,
  output logic        status_exl_set,
  output logic        status_exl_clr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_e      state, state_n;
  kind_e       ev_kind;
  logic [31:0] ev_pc, ev_bv, target;
  logic [4:0]  ev_code;
  logic        ev_ds;
  logic [3:0]  flush_cnt;
  logic        int_req, accept;

  logic unused_bits;
  assign unused_bits = ^{cp0_Status[31:16], cp0_Status[7:2], cp0_Cause[31:10], cp0_Cause[7:0]};

  cp0_int_detect u_int_detect (
    .ie      (cp0_Status[0]),
    .exl     (cp0_Status[1]),
    .im      (cp0_Status[15:8]),
    .sw_ip   (cp0_Cause[9:8]),
    .hw_int  (hw_int),
    .int_req (int_req)
  );

  assign accept = (state == ST_IDLE) & wb_valid & (int_req | wb_is_exc | wb_is_eret);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      ev_kind   <= EV_NONE;
      ev_pc     <= '0;
      ev_bv     <= '0;
      ev_code   <= '0;
      ev_ds     <= 1'b0;
      flush_cnt <= '0;
      target    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        ev_kind <= int_req ? EV_INT : (wb_is_exc ? EV_EXC : EV_ERET);
        ev_code <= int_req ? EXC_INT : wb_excCode;
        ev_pc   <= wb_pc;
        ev_bv   <= wb_badvaddr;
        ev_ds   <= wb_is_in_ds;
      end
      // ERET returns to the EPC as it stands in the commit cycle
      if (state == ST_COMMIT) begin
        flush_cnt <= 4'd1;
        target    <= (ev_kind == EV_ERET) ? cp0_EPC : EXC_VECTOR;
      end else if (state == ST_FLUSH) begin
        flush_cnt <= flush_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:     if (accept) state_n = ST_COMMIT;
      ST_COMMIT:   state_n = (FLUSH_CYCLES <= 1) ? ST_REDIRECT : ST_FLUSH;
      ST_FLUSH:    if (flush_cnt >= FLUSH_LAST) state_n = ST_REDIRECT;
      ST_REDIRECT: if (redirect_ack) state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    epc_we         = 1'b0;
    epc_wdata      = '0;
    cause_we       = 1'b0;
    cause_excCode  = '0;
    cause_bd       = 1'b0;
    badvaddr_we    = 1'b0;
    badvaddr_wdata = '0;
    status_exl_set = 1'b0;
    status_exl_clr = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    busy           = (state != ST_IDLE);
    case (state)
      ST_COMMIT: begin
        flush = 1'b1;
        if (ev_kind == EV_ERET) begin
          status_exl_clr = 1'b1;
        end else begin
          status_exl_set = 1'b1;
          cause_we       = 1'b1;
          cause_excCode  = ev_code;
          cause_bd       = ev_ds;
          // nested exception keeps the original return address
          if (!cp0_Status[1]) begin
            epc_we    = 1'b1;
            epc_wdata = ev_ds ? (ev_pc - 32'd4) : ev_pc;
          end
          if ((ev_kind == EV_EXC) && is_addr_err(ev_code)) begin
            badvaddr_we    = 1'b1;
            badvaddr_wdata = ev_bv;
          end
        end
      end
      ST_FLUSH: flush = 1'b1;
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target;
      end
      default: ;
    endcase
  end

endmodule
